sll_iter_32: RTL and testbench

//  Iterative, multi-cycle logical LEFT shifter: the left-direction counterpart of the ALU's

---
 rtl/alu_pkg.sv | 17 +
 rtl/sll_stage_var.sv | 25 ++
 rtl/sll_iter_32.sv | 103 ++++++++++
 tb/tb_sll_iter_32.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and the state encoding of the iterative shifter.
package alu_pkg;

  // Operand/result width and the matching shift-amount width (log2 of WIDTH).
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // State encoding of the iterative shifter FSM.
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT
  } state_t;

endpackage : alu_pkg

// File: rtl/sll_stage_var.sv
// One variable power-of-two left-shift stage: shifts by 2**sel when enabled.
// Zero-fills the LSBs; bits pushed past the MSB are dropped.
module sll_stage_var
  import alu_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int SW = SHAMT_W
) (
  input  logic [W-1:0]  data_in,
  input  logic          en,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  data_out
);

  // Apply the 2**sel shift only when this stage's amount bit is set.
  always_comb begin
    data_out = data_in;
    if (en) begin
      data_out = data_in << (32'd1 << sel);
    end else begin
      data_out = data_in;
    end
  end

endmodule : sll_stage_var

// File: rtl/sll_iter_32.sv
// Iterative 32-bit logical left shifter with a start/ready handshake.
// One power-of-two stage is applied per clock, so every shift takes exactly
// SHAMT_W cycles regardless of the amount; the stage is reused each cycle.
module sll_iter_32
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               ctrl_busy
);

  localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

  state_t             state;
  state_t             state_next;
  logic [SHAMT_W-1:0] stage;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   stage_out;
  logic               accept;
  logic               finish;

  // The single shared shift stage, steered by the current stage index.
  sll_stage_var #(
    .W  (WIDTH),
    .SW (SHAMT_W)
  ) u_stage (
    .data_in  (work),
    .en       (amt[stage]),
    .sel      (stage),
    .data_out (stage_out)
  );

  // Next-state logic: accept a request only when idle, finish on the last stage.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_start) begin
          state_next = ST_SHIFT;
          accept     = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (stage == LAST_STAGE) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any shift in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: capture operands on accept, step one stage per cycle, publish on finish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage          <= '0;
      work           <= '0;
      amt            <= '0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (accept) begin
        work  <= data_operandA;
        amt   <= ctrl_shiftamt;
        stage <= '0;
      end else if (state == ST_SHIFT) begin
        work  <= stage_out;
        stage <= finish ? '0 : stage + SHAMT_W'(1);
      end
      if (finish) begin
        data_result <= stage_out;
      end
    end
  end

  // Busy is a direct decode of the state register.
  assign ctrl_busy = (state == ST_SHIFT);

endmodule : sll_iter_32

// File: tb/tb_sll_iter_32.sv
// Self-checking bench for sll_iter_32: directed table, multi-cycle corner
// sequences, and randomized back-to-back shifts against a plain A<<amt model.
module tb_sll_iter_32;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        ctrl_busy;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_exp;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[5];

  sll_iter_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .ctrl_busy      (ctrl_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Reference model: logical left shift truncated to 32 bits.
  function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [4:0] s);
    logic [63:0] wide;
    wide = {32'd0, a} * (64'd1 << s);
    return wide[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request now (away from an edge) and follow it to its RDY cycle.
  // Returns at E5+1, i.e. inside the RDY cycle, so the next call is back-to-back.
  task automatic run_check(input logic [31:0] a, input logic [4:0] s,
                           input logic [31:0] exp, input string nm);
    int n;
    ctrl_start    = 1'b1;
    data_operandA = a;
    ctrl_shiftamt = s;
    @(posedge clock); #1;
    ctrl_start    = 1'b0;
    data_operandA = $urandom;
    ctrl_shiftamt = 5'($urandom);
    chk({nm, " busy_after_accept"}, {31'd0, ctrl_busy}, 32'd1);
    chk({nm, " rdy_low_after_accept"}, {31'd0, data_resultRDY}, 32'd0);
    chk({nm, " result_undisturbed"}, data_result, last_exp);
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 12) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, " latency"}, n, 32'd5);
    chk({nm, " result"}, data_result, exp);
    chk({nm, " busy_in_rdy"}, {31'd0, ctrl_busy}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int n;
    n_checks      = 0;
    n_fail        = 0;
    last_exp      = 32'd0;
    ctrl_start    = 1'b0;
    data_operandA = 32'd0;
    ctrl_shiftamt = 5'd0;
    reset         = 1'b1;

    tbl[0] = '{a: 32'h0000_0001, s: 5'd31, exp: 32'h8000_0000, name: "a1_s31"};
    tbl[1] = '{a: 32'hDEAD_BEEF, s: 5'd0,  exp: 32'hDEAD_BEEF, name: "s0"};
    tbl[2] = '{a: 32'h0000_ABCD, s: 5'd16, exp: 32'hABCD_0000, name: "s16"};
    tbl[3] = '{a: 32'h1234_5678, s: 5'd8,  exp: 32'h3456_7800, name: "s8"};
    tbl[4] = '{a: 32'hFFFF_FFFF, s: 5'd4,  exp: 32'hFFFF_FFF0, name: "ones_s4"};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset result", data_result, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, ctrl_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_check(tbl[i].a, tbl[i].s, tbl[i].exp, tbl[i].name);
      @(posedge clock); #1;
      chk({tbl[i].name, " rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
    end

    // Result holds across idle cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("hold result", data_result, 32'hFFFF_FFF0);
    end

    // Start while busy is ignored
    ctrl_start = 1'b1; data_operandA = 32'h1; ctrl_shiftamt = 5'd1;
    @(posedge clock); #1;               // E0
    ctrl_start = 1'b0;
    @(posedge clock); #1;               // E1
    ctrl_start = 1'b1; data_operandA = 32'h3; ctrl_shiftamt = 5'd2;
    @(posedge clock); #1;               // E2 (start ignored)
    ctrl_start = 1'b0;
    chk("busy_start busy", {31'd0, ctrl_busy}, 32'd1);
    n = 2;
    while (data_resultRDY !== 1'b1 && n < 12) begin
      @(posedge clock); #1;
      n++;
    end
    chk("busy_start latency", n, 32'd5);
    chk("busy_start result", data_result, 32'h2);
    last_exp = 32'h2;

    // Start in the RDY cycle is accepted
    run_check(32'h3, 5'd2, 32'hC, "rdy_cycle_start");
    @(posedge clock); #1;

    // Asynchronous reset mid-run
    @(negedge clock);
    ctrl_start = 1'b1; data_operandA = 32'h55; ctrl_shiftamt = 5'd3;
    @(posedge clock); #1;               // E0
    ctrl_start = 1'b0;
    repeat (3) @(posedge clock);        // E3
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset result", data_result, 32'd0);
    chk("async_reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("async_reset busy", {31'd0, ctrl_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      chk("post_reset no_rdy", {31'd0, data_resultRDY}, 32'd0);
    end
    last_exp = 32'd0;
    run_check(32'h55, 5'd3, 32'h2A8, "after_reset");

    // Randomized back-to-back shifts against the model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [4:0]  s;
      a = $urandom;
      s = 5'($urandom_range(0, 31));
      run_check(a, s, ref_sll(a, s), $sformatf("rand%0d", i));
    end
    @(posedge clock); #1;
    chk("rand last rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sll_iter_32
